// File: rtl/fpu_normalize_if.sv
// Handshake/data bundle for the FPU normalize/pack stage.
// master = upstream/downstream environment, slave = the normalize block.
interface fpu_normalize_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [8:0]  in_exponent;
    logic [24:0] in_mantissa;
    logic [1:0]  in_operator;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        flag_zero;
    logic        flag_overflow;
    logic        flag_underflow;
    logic        flag_invalid;

    modport master (
        output in_valid, in_sign, in_exponent, in_mantissa, in_operator, out_ready,
        input  in_ready, out_valid, result, flag_zero, flag_overflow, flag_underflow, flag_invalid
    );

    modport slave (
        input  in_valid, in_sign, in_exponent, in_mantissa, in_operator, out_ready,
        output in_ready, out_valid, result, flag_zero, flag_overflow, flag_underflow, flag_invalid
    );
endinterface

// File: rtl/fpu_normalize.sv
// FPU normalize/pack stage: renormalizes a raw add/sub/mul result and packs an IEEE-754 single.
// Optional FPU_NORM_ROUND_EN keeps the right-shifted bit and rounds to nearest-even before packing.
module fpu_normalize #(
    parameter int BIAS  = 127,
    parameter int EXP_W = 10
) (
    input logic            clk,
    input logic            reset,
    fpu_normalize_if.slave bus
);
    typedef enum logic [1:0] {IDLE, NORM, PACK, DONE} state_t;

    typedef struct packed {
        logic zero;
        logic overflow;
        logic underflow;
        logic invalid;
    } flags_t;

    localparam logic signed [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
    localparam logic signed [EXP_W-1:0] EXP_ZERO = '0;
    localparam logic signed [EXP_W-1:0] EXP_MAX  = EXP_W'(255);
    localparam logic signed [EXP_W-1:0] EXP_BIAS = EXP_W'(BIAS);

    state_t                  state_q, state_d;
    logic                    sign_q, sign_d;
    logic signed [EXP_W-1:0] exp_q, exp_d;
    logic [24:0]             mant_q, mant_d;
    logic [1:0]              op_q, op_d;
    logic [31:0]             result_q, result_d;
    flags_t                  flags_q, flags_d;
    logic                    out_valid_q, out_valid_d;
    logic [24:0]             mant_pk;
    logic                    pack_now;
`ifdef FPU_NORM_ROUND_EN
    logic                    round_q, round_d;  // bit dropped by the last right shift
    logic                    carry_q, carry_d;  // rounding carried out; next right shift lands normalized
`endif

    always_comb begin
        // NOTE: every next value defaults to its held value first, so no branch can infer a latch.
        state_d     = state_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        mant_d      = mant_q;
        op_d        = op_q;
        result_d    = result_q;
        flags_d     = flags_q;
        out_valid_d = out_valid_q;
        mant_pk     = mant_q;
        pack_now    = 1'b1;
`ifdef FPU_NORM_ROUND_EN
        round_d = round_q;
        carry_d = carry_q;
        // Round-half-even with no sticky bits: a set round bit is always an exact tie.
        if (round_q && mant_q[0])
            mant_pk = mant_q + 25'd1;
        if (mant_pk[24])
            pack_now = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_d = bus.in_sign;
                    mant_d = bus.in_mantissa;
                    op_d   = bus.in_operator;
                    exp_d  = EXP_W'(bus.in_exponent);
                    if (bus.in_operator == 2'b10)
                        exp_d = EXP_W'(bus.in_exponent) - EXP_BIAS;
`ifdef FPU_NORM_ROUND_EN
                    round_d = 1'b0;
                    carry_d = 1'b0;
`endif
                    state_d = NORM;
                end
            end

            NORM: begin
                if (mant_q == '0 || op_q == 2'b11) begin
                    state_d = PACK;
                end else if (mant_q[24]) begin
                    mant_d = {1'b0, mant_q[24:1]};
                    exp_d  = exp_q + EXP_ONE;
`ifdef FPU_NORM_ROUND_EN
                    round_d = mant_q[0];
                    if (carry_q) begin
                        carry_d = 1'b0;
                        state_d = PACK;
                    end
`endif
                end else if (!mant_q[23]) begin
                    mant_d = {mant_q[23:0], 1'b0};
                    exp_d  = exp_q - EXP_ONE;
                end else begin
                    state_d = PACK;
                end
            end

            PACK: begin
                if (!pack_now) begin
                    mant_d  = mant_pk;
`ifdef FPU_NORM_ROUND_EN
                    round_d = 1'b0;
                    carry_d = 1'b1;
`endif
                    state_d = NORM;
                end else begin
                    flags_d     = '0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                    if (op_q == 2'b11) begin
                        result_d         = 32'h7FC0_0000;
                        flags_d.invalid  = 1'b1;
                    end else if (mant_pk == '0) begin
                        result_d         = {sign_q, 31'b0};
                        flags_d.zero     = 1'b1;
                    end else if (exp_q >= EXP_MAX) begin
                        result_d         = {sign_q, 8'hFF, 23'b0};
                        flags_d.overflow = 1'b1;
                    end else if (exp_q <= EXP_ZERO) begin
                        result_d          = {sign_q, 31'b0};
                        flags_d.underflow = 1'b1;
                        flags_d.zero      = 1'b1;
                    end else begin
                        result_d = {sign_q, exp_q[7:0], mant_pk[22:0]};
                    end
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            mant_q      <= '0;
            op_q        <= '0;
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
`ifdef FPU_NORM_ROUND_EN
            round_q     <= 1'b0;
            carry_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            mant_q      <= mant_d;
            op_q        <= op_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
`ifdef FPU_NORM_ROUND_EN
            round_q     <= round_d;
            carry_q     <= carry_d;
`endif
        end
    end

    assign bus.in_ready       = (state_q == IDLE);
    assign bus.out_valid      = out_valid_q;
    assign bus.result         = result_q;
    assign bus.flag_zero      = flags_q.zero;
    assign bus.flag_overflow  = flags_q.overflow;
    assign bus.flag_underflow = flags_q.underflow;
    assign bus.flag_invalid   = flags_q.invalid;
endmodule

// File: tb/tb_fpu_normalize.sv
// Self-checking bench for fpu_normalize: directed corner cases plus randomized operands
// compared against an arithmetic reference model (leading-one position, not shift-by-shift).
module tb_fpu_normalize;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fpu_normalize_if bus ();

    fpu_normalize dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // flg = {zero, overflow, underflow, invalid}
    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
    } expect_t;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
        end
    endtask

    function automatic expect_t model(input bit s, input int e9, input longint m, input int op);
        expect_t r;
        int      e;
        int      p;
        longint  mm;
        r.lat = 3;
        e     = e9 - ((op == 2) ? 127 : 0);
        if (op == 3) begin
            r.res = 32'h7FC0_0000;
            r.flg = 4'b0001;
            return r;
        end
        if (m == 0) begin
            r.res = {s, 31'b0};
            r.flg = 4'b1000;
            return r;
        end
        p = 24;
        while (((m >> p) & 1) == 0) p--;
        if (p == 24) begin
            mm = m >> 1;
            e  = e + 1;
            r.lat++;
        end else begin
            mm    = m << (23 - p);
            e     = e - (23 - p);
            r.lat = r.lat + (23 - p);
        end
`ifdef FPU_NORM_ROUND_EN
        if (p == 24 && (m & 1) != 0 && (mm & 1) != 0) begin
            mm = mm + 1;
            if (mm >= (64'd1 << 24)) begin
                mm    = mm >> 1;
                e     = e + 1;
                r.lat = r.lat + 2;
            end
        end
`endif
        if (e >= 255) begin
            r.res = {s, 8'hFF, 23'b0};
            r.flg = 4'b0100;
        end else if (e <= 0) begin
            r.res = {s, 31'b0};
            r.flg = 4'b1010;
        end else begin
            r.res = {s, 8'(e), 23'(mm)};
            r.flg = 4'b0000;
        end
        return r;
    endfunction

    function automatic logic [3:0] dut_flags();
        return {bus.flag_zero, bus.flag_overflow, bus.flag_underflow, bus.flag_invalid};
    endfunction

    task automatic scramble_inputs();
        bus.in_sign     = 1'($urandom);
        bus.in_exponent = 9'($urandom);
        bus.in_mantissa = 25'($urandom);
        bus.in_operator = 2'($urandom);
    endtask

    task automatic run_txn(input string tag, input bit s, input int e9, input int m, input int op,
                           input int hold, input bit has_ref, input logic [31:0] ref_res,
                           input int ref_lat);
        expect_t x;
        int      lat;
        x = model(s, e9, longint'(m), op);
        @(negedge clk);
        check({tag, ".in_ready"}, bus.in_ready, 1'b1);
        bus.in_valid    = 1'b1;
        bus.in_sign     = s;
        bus.in_exponent = 9'(e9);
        bus.in_mantissa = 25'(m);
        bus.in_operator = 2'(op);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        scramble_inputs();
        lat = 1;
        while (!bus.out_valid && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ".lat"}, lat, x.lat);
        if (!bus.out_valid) begin
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            return;
        end
        check({tag, ".result"}, bus.result, x.res);
        check({tag, ".flags"}, dut_flags(), x.flg);
        if (has_ref) begin
            check({tag, ".ref_result"}, bus.result, ref_res);
            check({tag, ".ref_lat"}, lat, ref_lat);
        end
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            scramble_inputs();
            @(posedge clk);
            #1;
            check({tag, ".hold_valid"}, bus.out_valid, 1'b1);
            check({tag, ".hold_ready"}, bus.in_ready, 1'b0);
            check({tag, ".hold_result"}, bus.result, x.res);
            check({tag, ".hold_flags"}, dut_flags(), x.flg);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check({tag, ".drop_valid"}, bus.out_valid, 1'b0);
        check({tag, ".back_idle"}, bus.in_ready, 1'b1);
    endtask

    task automatic reset_mid_norm();
        bit seen;
        @(negedge clk);
        bus.in_valid    = 1'b1;
        bus.in_sign     = 1'b0;
        bus.in_exponent = 9'd127;
        bus.in_mantissa = 25'd1;
        bus.in_operator = 2'b01;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid.in_ready", bus.in_ready, 1'b1);
        check("rst_mid.out_valid", bus.out_valid, 1'b0);
        check("rst_mid.result", bus.result, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        seen  = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        check("rst_mid.never_valid", seen, 1'b0);
    endtask

    initial begin
        int      op;
        int      e9;
        int      k;
        int      m;
        bit      s;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_sign     = 1'b0;
        bus.in_exponent = '0;
        bus.in_mantissa = '0;
        bus.in_operator = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.out_valid", bus.out_valid, 1'b0);
        check("reset.in_ready", bus.in_ready, 1'b1);
        check("reset.result", bus.result, 32'h0);
        check("reset.flags", dut_flags(), 4'b0000);
        @(negedge clk);
        reset = 1'b0;

        run_txn("add_norm",  1'b0, 130, 32'h0C0_0000, 0, 0, 1'b1, 32'h4140_0000, 3);
        run_txn("add_carry", 1'b0, 127, 32'h180_0000, 0, 0, 1'b1, 32'h4040_0000, 4);
        run_txn("add_ovf",   1'b0, 254, 32'h100_0000, 0, 0, 1'b1, 32'h7F80_0000, 4);
        run_txn("sub_23",    1'b0, 127, 32'h000_0001, 1, 0, 1'b1, 32'h3400_0000, 26);
        run_txn("sub_unf",   1'b0, 10,  32'h000_0001, 1, 0, 1'b1, 32'h0000_0000, 26);
        run_txn("mul_one",   1'b0, 254, 32'h080_0000, 2, 0, 1'b1, 32'h3F80_0000, 3);
        run_txn("mul_zero",  1'b1, 254, 32'h000_0000, 2, 0, 1'b1, 32'h8000_0000, 3);
        run_txn("illegal",   1'b1, 200, 32'h0C0_0000, 3, 0, 1'b1, 32'h7FC0_0000, 3);
        run_txn("hold5",     1'b0, 130, 32'h0C0_0000, 0, 5, 1'b1, 32'h4140_0000, 3);
`ifdef FPU_NORM_ROUND_EN
        run_txn("rnd_carry", 1'b0, 127, 32'h1FF_FFFF, 0, 0, 1'b1, 32'h4080_0000, 6);
        run_txn("rnd_odd",   1'b0, 127, 32'h100_0003, 0, 0, 1'b1, 32'h4000_0002, 4);
        run_txn("rnd_even",  1'b0, 127, 32'h100_0001, 0, 0, 1'b1, 32'h4000_0000, 4);
`else
        run_txn("trunc_max", 1'b0, 127, 32'h1FF_FFFF, 0, 0, 1'b1, 32'h407F_FFFF, 4);
        run_txn("trunc_odd", 1'b0, 127, 32'h100_0003, 0, 0, 1'b1, 32'h4000_0001, 4);
`endif
        reset_mid_norm();

        for (int i = 0; i < 150; i++) begin
            op = ($urandom_range(0, 15) == 0) ? 3 : int'($urandom_range(0, 2));
            e9 = (op == 2) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 255));
            k  = $urandom_range(0, 25);
            m  = (k == 0) ? 0 : (int'($urandom) & ((1 << k) - 1)) | (1 << (k - 1));
            s  = 1'($urandom);
            run_txn($sformatf("rand%0d", i), s, e9, m, op, int'($urandom_range(0, 2)),
                    1'b0, 32'h0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
